// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one W-bit ALU between two valid/ready requesters.
// Define ALU_ARB_FLAGS_EN to add registered resp_zero / resp_cout outputs.
module alu_rr_arbiter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         resp0_valid,
  input  logic         resp0_ready,
  output logic         resp1_valid,
  input  logic         resp1_ready,
  output logic [W-1:0] resp_data,
`ifdef ALU_ARB_FLAGS_EN
  output logic         resp_zero,
  output logic         resp_cout,
`endif
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e       state_q;
  logic [W-1:0] op_a_q;
  logic [W-1:0] op_b_q;
  logic [2:0]   op_code_q;
  logic         owner_q;
  logic         last_grant_q;
  logic [W-1:0] resp_data_q;
  logic         resp0_valid_q;
  logic         resp1_valid_q;
  logic         busy_q;

  logic         any_v;
  logic         gnt;
  logic         idle;
  logic         accept;
  logic         resp_rdy;
  logic [W-1:0] alu_res;

  assign idle  = (state_q == IDLE);
  assign any_v = req0_valid | req1_valid;

  // Tie goes to whoever did not win last time.
  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      (req0_valid && req1_valid): gnt = ~last_grant_q;
      (req1_valid && !req0_valid): gnt = 1'b1;
      default: gnt = 1'b0;
    endcase
  end

  assign req0_ready = idle && any_v && !gnt;
  assign req1_ready = idle && any_v && gnt;
  assign accept     = (req0_valid && req0_ready)
                   || (req1_valid && req1_ready);
  assign resp_rdy   = owner_q ? resp1_ready : resp0_ready;

  always_comb begin
    alu_res = '0;
    case (op_code_q)
      3'b000:  alu_res = op_a_q + op_b_q;
      3'b001:  alu_res = op_a_q - op_b_q;
      3'b010:  alu_res = op_a_q | op_b_q;
      3'b011:  alu_res = op_a_q & op_b_q;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_ARB_FLAGS_EN
  logic alu_cout;
  logic zero_q;
  logic cout_q;

  // A wrapped sum is smaller than either addend.
  always_comb begin
    alu_cout = 1'b0;
    case (op_code_q)
      3'b000:  alu_cout = (alu_res < op_a_q);
      3'b001:  alu_cout = (op_a_q < op_b_q);
      default: alu_cout = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q <= 1'b0;
      cout_q <= 1'b0;
    end else if (state_q == EXEC) begin
      zero_q <= (alu_res == '0);
      cout_q <= alu_cout;
    end
  end

  assign resp_zero = zero_q;
  assign resp_cout = cout_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_code_q     <= '0;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      resp_data_q   <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= EXEC;
            op_a_q       <= gnt ? req1_a : req0_a;
            op_b_q       <= gnt ? req1_b : req0_b;
            op_code_q    <= gnt ? req1_op : req0_op;
            owner_q      <= gnt;
            last_grant_q <= gnt;
            busy_q       <= 1'b1;
          end
        end
        EXEC: begin
          state_q       <= RESP;
          resp_data_q   <= alu_res;
          resp0_valid_q <= !owner_q;
          resp1_valid_q <= owner_q;
        end
        RESP: begin
          if (resp_rdy) begin
            state_q       <= IDLE;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
            busy_q        <= 1'b0;
          end
        end
        default: begin
          state_q       <= IDLE;
          resp0_valid_q <= 1'b0;
          resp1_valid_q <= 1'b0;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign resp_data   = resp_data_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: cycle model predicts grants and results.
// Define ALU_ARB_FLAGS_EN to also check resp_zero / resp_cout.
module tb_alu_rr_arbiter;
  localparam int W = 5;

  logic clk = 0;
  logic reset = 1;
  logic req0_valid = 0, req1_valid = 0;
  logic req0_ready, req1_ready;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic resp0_valid, resp1_valid;
  logic resp0_ready = 1, resp1_ready = 1;
  logic [W-1:0] resp_data;
  logic busy;
`ifdef ALU_ARB_FLAGS_EN
  logic resp_zero, resp_cout;
`endif

  alu_rr_arbiter #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_data(resp_data),
`ifdef ALU_ARB_FLAGS_EN
    .resp_zero(resp_zero), .resp_cout(resp_cout),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cycle = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d",
               name, cycle, act, exp);
    end
  endtask

  typedef struct {
    int port;
    int data;
    int zero;
    int cout;
    int due;
  } exp_t;

  exp_t sb[$];
  int   hs_port[$];
  int   hs_cyc[$];
  bit   pend = 0;
  int   last_g = 1;
  int   free_at = 0;

  function automatic exp_t model(input int p, input int a, input int b,
                                 input int op, input int c);
    exp_t e;
    int m = 1 << W;
    e.port = p;
    e.cout = 0;
    case (op)
      0: begin e.data = (a + b) % m; e.cout = (a + b >= m); end
      1: begin e.data = (a - b + m) % m; e.cout = (a < b); end
      2: e.data = a | b;
      3: e.data = a & b;
      default: e.data = 0;
    endcase
    e.zero = (e.data == 0);
    e.due = c + 2;
    return e;
  endfunction

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: predicts handshakes and responses from the arbitration rules.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_rv0", resp0_valid, 0);
      chk("rst_rv1", resp1_valid, 0);
      chk("rst_data", resp_data, 0);
      sb.delete();
      pend = 0;
      last_g = 1;
      free_at = 0;
    end else begin
      bit free;
      bit any;
      int g;
      free = !pend && (cycle >= free_at);
      any = req0_valid || req1_valid;
      g = (req0_valid && req1_valid) ? 1 - last_g : (req1_valid ? 1 : 0);
      chk("busy", busy, !free);
      chk("req0_ready", req0_ready, free && any && g == 0);
      chk("req1_ready", req1_ready, free && any && g == 1);
      if (free && any) begin
        if (g == 0)
          sb.push_back(model(0, req0_a, req0_b, req0_op, cycle));
        else
          sb.push_back(model(1, req1_a, req1_b, req1_op, cycle));
        hs_port.push_back(g);
        hs_cyc.push_back(cycle);
        last_g = g;
        pend = 1;
      end
      if (sb.size() > 0 && cycle >= sb[0].due) begin
        chk("resp0_valid", resp0_valid, sb[0].port == 0);
        chk("resp1_valid", resp1_valid, sb[0].port == 1);
        chk("resp_data", resp_data, sb[0].data);
`ifdef ALU_ARB_FLAGS_EN
        chk("resp_zero", resp_zero, sb[0].zero);
        chk("resp_cout", resp_cout, sb[0].cout);
`endif
        if ((sb[0].port == 0) ? resp0_ready : resp1_ready) begin
          void'(sb.pop_front());
          pend = 0;
          free_at = cycle + 1;
        end
      end else begin
        chk("resp0_idle", resp0_valid, 0);
        chk("resp1_idle", resp1_valid, 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input int a, input int b, input int op);
    bit done = 0;
    int n = 0;
    if (p == 0) begin
      req0_valid = 1; req0_a = W'(a); req0_b = W'(b); req0_op = 3'(op);
    end else begin
      req1_valid = 1; req1_a = W'(a); req1_b = W'(b); req1_op = 3'(op);
    end
    while (!done && n < 50) begin
      @(negedge clk);
      done = (p == 0) ? req0_ready : req1_ready;
      step(1);
      n++;
    end
    if (p == 0) req0_valid = 0;
    else req1_valid = 0;
    chk("send_handshake", done, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      step(1);
      n++;
    end
    chk("idle_timeout", busy, 0);
    step(1);
  endtask

  initial begin
    step(3);
    reset = 0;
    step(2);

    send(0, 3, 4, 0);
    wait_idle();
    send(1, 2, 5, 1);
    wait_idle();

    // Continuous tie: grants must alternate, one every 3 cycles.
    hs_port.delete();
    hs_cyc.delete();
    req0_a = 12; req0_b = 3; req0_op = 3'b010;
    req1_a = 12; req1_b = 6; req1_op = 3'b011;
    req0_valid = 1;
    req1_valid = 1;
    step(13);
    req0_valid = 0;
    req1_valid = 0;
    wait_idle();
    chk("alt_count", hs_port.size() >= 4, 1);
    for (int i = 1; i < hs_port.size(); i++) begin
      chk("alt_port", hs_port[i], 1 - hs_port[i-1]);
      chk("alt_gap", hs_cyc[i] - hs_cyc[i-1], 3);
    end

    // Response stall on port 0 while port 1 keeps requesting.
    resp0_ready = 0;
    resp1_ready = 1;
    send(0, 1, 2, 0);
    req1_valid = 1; req1_a = 7; req1_b = 7; req1_op = 0;
    step(12);
    req1_valid = 0;
    resp0_ready = 1;
    wait_idle();

    // Reset during EXEC aborts the op and restores the tie order.
    send(1, 9, 9, 4);
    reset = 1;
    step(2);
    req0_valid = 1;
    req1_valid = 1;
    reset = 0;
    req0_a = 5; req0_b = 6; req0_op = 0;
    begin
      int n = 0;
      bit got = 0;
      while (!got && n < 10) begin
        @(negedge clk);
        got = req0_ready || req1_ready;
        chk("tie_after_reset", req1_ready, 0);
        step(1);
        n++;
      end
      chk("tie_handshake", got, 1);
    end
    req0_valid = 0;
    req1_valid = 0;
    wait_idle();

    send(0, 16, 16, 0);
    wait_idle();

    for (int i = 0; i < 400; i++) begin
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      req0_a = W'($urandom); req0_b = W'($urandom);
      req1_a = W'($urandom); req1_b = W'($urandom);
      req0_op = 3'($urandom_range(0, 7));
      req1_op = 3'($urandom_range(0, 7));
      resp0_ready = ($urandom_range(0, 99) < 70);
      resp1_ready = ($urandom_range(0, 99) < 70);
      step(1);
    end
    req0_valid = 0;
    req1_valid = 0;
    resp0_ready = 1;
    resp1_ready = 1;
    wait_idle();
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
